processor_core_param: RTL and testbench
=======================================

Name: processor_core_param

Overview:
- Parametrised multicycle processor core; successor to the fixed 16-bit processor_verilog.
- Generalised datapath width, PC width and register count.
- Instruction memory is external, behind a variable-latency req/ack handshake.
- Adds single-step debug mode, HALT/resume, and an illegal-opcode flag; exposes data bus, state and PC for the bench.

Parameters:
DATA_WIDTH, 16, register/ALU/data_output width (>=8)
PC_WIDTH, 16, program counter and imem_addr width
NUM_REGS, 4, register count (2..16); register index = field value mod NUM_REGS

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
imem_req  out  1  instruction fetch request
imem_addr  out  PC_WIDTH  fetch address, equals PC while imem_req=1
imem_ack  in  1  instruction valid; sampled only in WAIT
imem_data  in  16  instruction word, captured when imem_ack=1 in WAIT
step_mode  in  1  1 = single-step enabled
step  in  1  one-cycle pulse releasing one instruction in step mode
resume  in  1  leave HALT
data_output  out  DATA_WIDTH  last value written by OUT
current_state_output  out  3  FSM state code
pc_output  out  PC_WIDTH  current PC
halted  out  1  1 while in HALT
illegal_op  out  1  sticky; set on undefined opcode

Behaviour:
- Reset (reset=0, async): state=FETCH, PC=0, all registers=0, data_output=0, illegal_op=0, instruction latch=0, imem_req=0.
- State codes: FETCH=0, WAIT=1, DECODE=2, EXECUTE=3, WRITEBACK=4, HALT=7; 5 and 6 unused, recover to FETCH.
- FETCH:
  - If step_mode=1 and step=0: hold, imem_req=0.
  - Else: imem_req=1, imem_addr=PC, go to WAIT.
- WAIT: imem_req=1. On imem_ack=1, latch imem_data, go to DECODE; otherwise hold indefinitely.
- DECODE: latch operands R[rd], R[rs]. Go to EXECUTE.
- EXECUTE:
  - Compute ALU result and branch decision.
  - HALT goes to HALT with PC unchanged (still pointing at the HALT word).
  - All other opcodes go to WRITEBACK.
- WRITEBACK: write rd and/or data_output. PC <= branch target if taken, else PC+1 (wraps mod 2^PC_WIDTH). Go to FETCH.
- Minimum 5 cycles per instruction (ack in first WAIT cycle).
- Encoding: [15:12] op, [11:8] rd, [7:4] rs, [7:0] imm.
  - 0 NOP
  - 1 LDI: rd <= sign-extend(imm)
  - 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR: rd <= rd op rs, modulo 2^DATA_WIDTH, no flags
  - 7 OUT: data_output <= R[rs]
  - 8 JMP: PC <= zero-extend(imm)
  - 9 JZ: if R[rd]==0, PC <= zero-extend(imm)
  - F HALT
- Opcodes A..E: executed as NOP; illegal_op set at EXECUTE and held until reset.
- Register writes occur only in WRITEBACK. Same-register operands (e.g. ADD r1,r1) use pre-write values.
- HALT: halted=1, imem_req=0. resume=1 sets PC <= PC+1 and goes to FETCH. step is ignored in HALT.
- step_mode may change at any time; it takes effect only at FETCH. A step pulse outside FETCH is ignored (not queued).
- Reset mid-fetch (WAIT with req pending): imem_req drops immediately (async). A late ack is ignored because the state is no longer WAIT.

Test Plan:
- Program LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0; HALT, ack in first WAIT cycle -> data_output=0x0008, halted=1, pc_output=4, 5 cycles per instruction.
- LDI r0,0x80; OUT r0 -> data_output=0xFF80 (sign-extend). Repeat with DATA_WIDTH=8 -> 0x80.
- Ack delayed 3 cycles on every fetch -> state stays 1 for 4 cycles per fetch, imem_addr stable, identical final results.
- LDI r2,0; JZ r2,0x10 -> next imem_addr=0x0010. With r2=1 -> next imem_addr = PC+1.
- step_mode=1, no step for 10 cycles -> state=0, imem_req=0. One step pulse -> exactly one instruction executes, returns to FETCH and stalls.
- Opcode 0xA000 -> illegal_op=1 persists. Reset (reset=0) asserted during WAIT -> state=0, PC=0, all outputs cleared within the same cycle.

Source files
------------

// File: rtl/processor_core_param.sv
// Parametrised multicycle processor core.
// Every instruction runs FETCH -> WAIT -> DECODE -> EXECUTE -> WRITEBACK. The only
// exception is HALT, which leaves EXECUTE straight into the HALT state.
// Instruction words come from an external memory through a req/ack handshake.
// The ack may arrive after any number of cycles.
// A single-step mode gates FETCH, so exactly one instruction runs per step pulse.
module processor_core_param #(
    parameter int DATA_WIDTH = 16,
    parameter int PC_WIDTH   = 16,
    parameter int NUM_REGS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic                  imem_req,
    output logic [PC_WIDTH-1:0]   imem_addr,
    input  logic                  imem_ack,
    input  logic [15:0]           imem_data,
    input  logic                  step_mode,
    input  logic                  step,
    input  logic                  resume,
    output logic [DATA_WIDTH-1:0] data_output,
    output logic [2:0]            current_state_output,
    output logic [PC_WIDTH-1:0]   pc_output,
    output logic                  halted,
    output logic                  illegal_op
);

    localparam int IDX_W = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1;

    typedef enum logic [2:0] {
        S_FETCH     = 3'd0,
        S_WAIT      = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_HALT      = 3'd7
    } state_t;

    localparam logic [3:0] OP_LDI  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_OUT  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZ   = 4'h9;
    localparam logic [3:0] OP_HALT = 4'hF;

    state_t                state_reg;
    logic [PC_WIDTH-1:0]   pc_reg;
    logic [15:0]           instr_reg;
    logic [DATA_WIDTH-1:0] op_a_reg;
    logic [DATA_WIDTH-1:0] op_b_reg;
    logic [DATA_WIDTH-1:0] result_reg;
    logic [DATA_WIDTH-1:0] out_reg;
    logic                  take_branch_reg;
    logic                  illegal_reg;
    logic                  req_reg;
    logic [DATA_WIDTH-1:0] regs [NUM_REGS];

    // Instruction fields. Register numbers fold onto the implemented register count.
    logic [3:0]       opcode;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] rs_idx;
    logic [7:0]       imm;
    logic             writes_rd;

    assign opcode    = instr_reg[15:12];
    assign rd_idx    = IDX_W'(5'(instr_reg[11:8]) % 5'(NUM_REGS));
    assign rs_idx    = IDX_W'(5'(instr_reg[7:4]) % 5'(NUM_REGS));
    assign imm       = instr_reg[7:0];
    assign writes_rd = (opcode >= OP_LDI) && (opcode <= OP_XOR);

    // ALU result and branch decision, both taken from the operands latched in DECODE.
    logic [DATA_WIDTH-1:0] alu_result;
    logic                  branch_taken;
    logic                  is_illegal;

    always_comb begin
        alu_result   = op_a_reg;
        branch_taken = 1'b0;
        case (opcode)
            OP_LDI: alu_result   = DATA_WIDTH'($signed(imm));
            OP_ADD: alu_result   = op_a_reg + op_b_reg;
            OP_SUB: alu_result   = op_a_reg - op_b_reg;
            OP_AND: alu_result   = op_a_reg & op_b_reg;
            OP_OR:  alu_result   = op_a_reg | op_b_reg;
            OP_XOR: alu_result   = op_a_reg ^ op_b_reg;
            OP_JMP: branch_taken = 1'b1;
            OP_JZ:  branch_taken = (op_a_reg == '0);
            default: ;
        endcase
    end

    assign is_illegal = (opcode >= 4'hA) && (opcode <= 4'hE);

    // One-hot register write enables, asserted only in WRITEBACK.
    logic [NUM_REGS-1:0] reg_we;

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_reg_we
        assign reg_we[gi] = (state_reg == S_WRITEBACK) && writes_rd && (rd_idx == IDX_W'(gi));
    end

    // Register file. Operands are latched a full stage ahead of any write, so
    // same-register operands always see pre-write values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_we[i]) regs[i] <= result_reg;
            end
        end
    end

    // Main control FSM, together with its registered datapath state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg       <= S_FETCH;
            pc_reg          <= '0;
            instr_reg       <= '0;
            op_a_reg        <= '0;
            op_b_reg        <= '0;
            result_reg      <= '0;
            out_reg         <= '0;
            take_branch_reg <= 1'b0;
            illegal_reg     <= 1'b0;
            req_reg         <= 1'b0;
        end else begin
            case (state_reg)
                S_FETCH: begin
                    // In step mode the core parks here until a step pulse arrives.
                    if (!(step_mode && !step)) begin
                        req_reg   <= 1'b1;
                        state_reg <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_ack) begin
                        instr_reg <= imem_data;
                        req_reg   <= 1'b0;
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    op_a_reg  <= regs[rd_idx];
                    op_b_reg  <= regs[rs_idx];
                    state_reg <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    result_reg      <= alu_result;
                    take_branch_reg <= branch_taken;
                    if (is_illegal) illegal_reg <= 1'b1;
                    state_reg <= (opcode == OP_HALT) ? S_HALT : S_WRITEBACK;
                end
                S_WRITEBACK: begin
                    if (opcode == OP_OUT) out_reg <= op_b_reg;
                    pc_reg    <= take_branch_reg ? PC_WIDTH'(imm) : pc_reg + PC_WIDTH'(1);
                    state_reg <= S_FETCH;
                end
                S_HALT: begin
                    // The PC still points at the HALT word, so resume skips past it.
                    if (resume) begin
                        pc_reg    <= pc_reg + PC_WIDTH'(1);
                        state_reg <= S_FETCH;
                    end
                end
                default: state_reg <= S_FETCH;
            endcase
        end
    end

    assign imem_req             = req_reg;
    assign imem_addr            = pc_reg;
    assign data_output          = out_reg;
    assign current_state_output = state_reg;
    assign pc_output            = pc_reg;
    assign halted               = (state_reg == S_HALT);
    assign illegal_op           = illegal_reg;

endmodule

// File: tb/tb_processor_core_param.sv
// Bench for processor_core_param.
// An instruction-level reference model executes one whole instruction each time
// the core finishes one. A single negedge process compares the architectural
// outputs, handshake behaviour and per-instruction cycle counts against the model.
// Directed programs pin the model with hand-computed results.
// A randomized phase then runs random programs, ack delays, step and resume activity.
module tb_processor_core_param;

    localparam int DW = 16;
    localparam int PW = 16;
    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          imem_ack = 1'b0;
    logic [15:0]   imem_data = '0;
    logic          step_mode = 1'b0;
    logic          step = 1'b0;
    logic          resume = 1'b0;
    logic          imem_req;
    logic [PW-1:0] imem_addr;
    logic [DW-1:0] data_output;
    logic [2:0]    current_state_output;
    logic [PW-1:0] pc_output;
    logic          halted;
    logic          illegal_op;

    always #5 clk = ~clk;

    processor_core_param #(.DATA_WIDTH(DW), .PC_WIDTH(PW), .NUM_REGS(NR)) dut (
        .clk                  (clk),
        .reset                (reset),
        .imem_req             (imem_req),
        .imem_addr            (imem_addr),
        .imem_ack             (imem_ack),
        .imem_data            (imem_data),
        .step_mode            (step_mode),
        .step                 (step),
        .resume               (resume),
        .data_output          (data_output),
        .current_state_output (current_state_output),
        .pc_output            (pc_output),
        .halted               (halted),
        .illegal_op           (illegal_op)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] mem [256];
    int          dly_mode = 0;   // 0: ack at once, 1: ack after 3 cycles, 2: random table
    int          dly_tab [1024];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic int delay_for(input int idx);
        case (dly_mode)
            0:       return 0;
            1:       return 3;
            default: return dly_tab[idx % 1024];
        endcase
    endfunction

    // Memory responder. It returns garbage acks and data outside WAIT, and inside
    // WAIT it answers after the scheduled number of extra cycles.
    int r_idx = 0;
    int r_cnt = 0;
    always @(negedge clk) begin
        if (!reset) begin
            r_idx    = 0;
            r_cnt    = 0;
            imem_ack = 1'b0;
        end else if (current_state_output == 3'd1) begin
            if (r_cnt >= delay_for(r_idx)) begin
                imem_ack  = 1'b1;
                imem_data = mem[imem_addr[7:0]];
                r_idx++;
                r_cnt = 0;
            end else begin
                imem_ack  = 1'b0;
                imem_data = 16'($urandom);
                r_cnt++;
            end
        end else begin
            imem_ack  = 1'($urandom_range(0, 1));
            imem_data = 16'($urandom);
            r_cnt     = 0;
        end
    end

    // Reference model: architectural state only.
    logic [15:0] m_pc;
    logic [15:0] m_r [NR];
    logic [15:0] m_out;
    logic        m_ill;
    logic        m_halt;

    task automatic model_exec();
        logic [15:0] w;
        logic [3:0]  op;
        logic [7:0]  imm;
        logic [15:0] nxt;
        int          rd;
        int          rs;
        w   = mem[m_pc[7:0]];
        op  = w[15:12];
        rd  = int'(w[11:8]) % NR;
        rs  = int'(w[7:4]) % NR;
        imm = w[7:0];
        nxt = m_pc + 16'd1;
        case (op)
            4'h1: m_r[rd] = {{8{imm[7]}}, imm};
            4'h2: m_r[rd] = m_r[rd] + m_r[rs];
            4'h3: m_r[rd] = m_r[rd] - m_r[rs];
            4'h4: m_r[rd] = m_r[rd] & m_r[rs];
            4'h5: m_r[rd] = m_r[rd] | m_r[rs];
            4'h6: m_r[rd] = m_r[rd] ^ m_r[rs];
            4'h7: m_out = m_r[rs];
            4'h8: nxt = {8'h00, imm};
            4'h9: if (m_r[rd] == 16'd0) nxt = {8'h00, imm};
            4'hA, 4'hB, 4'hC, 4'hD, 4'hE: m_ill = 1'b1;
            4'hF: begin m_halt = 1'b1; nxt = m_pc; end
            default: ;
        endcase
        m_pc = nxt;
    endtask

    function automatic bit legal_next(input logic [2:0] a, input logic [2:0] b);
        case (a)
            3'd0:    return (b == 3'd0) || (b == 3'd1);
            3'd1:    return (b == 3'd1) || (b == 3'd2);
            3'd2:    return (b == 3'd3);
            3'd3:    return (b == 3'd4) || (b == 3'd7);
            3'd4:    return (b == 3'd0);
            3'd7:    return (b == 3'd7) || (b == 3'd0);
            default: return 1'b0;
        endcase
    endfunction

    // Compare process. It advances the model at instruction boundaries and checks
    // the outputs on every cycle.
    logic [2:0] prev_st = 3'd0;
    int         c_idx = 0;
    int         icyc = 0;
    always @(negedge clk) begin
        logic [2:0] st;
        if (!reset) begin
            m_pc = '0; m_out = '0; m_ill = 1'b0; m_halt = 1'b0;
            for (int i = 0; i < NR; i++) m_r[i] = '0;
            prev_st = 3'd0; c_idx = 0; icyc = 0;
        end else begin
            st = current_state_output;
            chk("state_seq", {31'd0, legal_next(prev_st, st)}, 32'd1);
            if (prev_st == 3'd4 && st == 3'd0) begin
                model_exec();
                chk("instr_cycles", icyc, delay_for(c_idx) + 4);
                c_idx++;
            end else if (prev_st == 3'd3 && st == 3'd7) begin
                model_exec();
                chk("halt_cycles", icyc, delay_for(c_idx) + 3);
                c_idx++;
            end else if (prev_st == 3'd7 && st == 3'd0) begin
                m_pc   = m_pc + 16'd1;
                m_halt = 1'b0;
            end
            if (st == 3'd1 && prev_st != 3'd1) icyc = 0;
            if (st inside {3'd1, 3'd2, 3'd3, 3'd4}) icyc++;
            chk("pc_output", pc_output, m_pc);
            chk("data_output", data_output, m_out);
            chk("halted", halted, m_halt);
            chk("imem_req", imem_req, st == 3'd1);
            if (imem_req) chk("imem_addr", imem_addr, m_pc);
            if (st != 3'd4) chk("illegal_op", illegal_op, m_ill);
            prev_st = st;
        end
    end

    task automatic assert_reset();
        reset  = 1'b0;
        step   = 1'b0;
        resume = 1'b0;
        @(posedge clk); #1;
        chk("rst_state", current_state_output, 3'd0);
        chk("rst_pc", pc_output, 16'd0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_data", data_output, 16'd0);
        chk("rst_illegal", illegal_op, 1'b0);
        chk("rst_halted", halted, 1'b0);
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
    endtask

    task automatic release_reset(input int mode, input logic smode);
        dly_mode  = mode;
        step_mode = smode;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic wait_halt(input int max, output int cyc);
        cyc = 0;
        while (!halted && cyc < max) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("halt_reached", halted, 1'b1);
    endtask

    task automatic pulse_resume();
        @(posedge clk); #1 resume = 1'b1;
        @(posedge clk); #1 resume = 1'b0;
    endtask

    task automatic pulse_step();
        @(posedge clk); #1 step = 1'b1;
        @(posedge clk); #1 step = 1'b0;
    endtask

    function automatic logic [15:0] gen_instr();
        int r;
        logic [3:0] op;
        r = $urandom_range(0, 99);
        if      (r < 20) op = 4'h1;
        else if (r < 45) op = 4'($urandom_range(2, 6));
        else if (r < 65) op = 4'h7;
        else if (r < 70) op = 4'h8;
        else if (r < 80) op = 4'h9;
        else if (r < 84) op = 4'h0;
        else if (r < 88) op = 4'($urandom_range(10, 14));
        else             op = 4'hF;
        return {op, 12'($urandom)};
    endfunction

    initial begin
        int cyc;
        for (int i = 0; i < 1024; i++) dly_tab[i] = $urandom_range(0, 3);

        // LDI r0,5; LDI r1,3; ADD r0,r1; OUT r0; HALT with immediate ack.
        assert_reset();
        mem[0] = 16'h1005; mem[1] = 16'h1103; mem[2] = 16'h2010;
        mem[3] = 16'h7000; mem[4] = 16'hF000;
        release_reset(0, 1'b0);
        wait_halt(200, cyc);
        chk("t1_cycles", cyc, 24);
        chk("t1_data", data_output, 16'h0008);
        chk("t1_pc", pc_output, 16'd4);

        // Same program, with every ack delayed by 3 cycles.
        assert_reset();
        mem[0] = 16'h1005; mem[1] = 16'h1103; mem[2] = 16'h2010;
        mem[3] = 16'h7000; mem[4] = 16'hF000;
        release_reset(1, 1'b0);
        wait_halt(200, cyc);
        chk("t1d_cycles", cyc, 39);
        chk("t1d_data", data_output, 16'h0008);
        chk("t1d_pc", pc_output, 16'd4);

        // Sign extension of the LDI immediate.
        assert_reset();
        mem[0] = 16'h1080; mem[1] = 16'h7000; mem[2] = 16'hF000;
        release_reset(0, 1'b0);
        wait_halt(200, cyc);
        chk("sext_data", data_output, 16'hFF80);
        chk("sext_pc", pc_output, 16'd2);

        // JZ taken.
        assert_reset();
        mem[0] = 16'h1200; mem[1] = 16'h9210; mem[2] = 16'hF000; mem[16] = 16'hF000;
        release_reset(0, 1'b0);
        wait_halt(200, cyc);
        chk("jz_taken_pc", pc_output, 16'h0010);

        // JZ not taken.
        assert_reset();
        mem[0] = 16'h1201; mem[1] = 16'h9210; mem[2] = 16'hF000; mem[16] = 16'hF000;
        release_reset(0, 1'b0);
        wait_halt(200, cyc);
        chk("jz_fall_pc", pc_output, 16'd2);

        // Single-step mode: each pulse releases exactly one instruction.
        assert_reset();
        mem[0] = 16'h1007; mem[1] = 16'h7000; mem[2] = 16'hF000;
        release_reset(0, 1'b1);
        repeat (10) @(posedge clk);
        #1;
        chk("step_idle_state", current_state_output, 3'd0);
        chk("step_idle_req", imem_req, 1'b0);
        chk("step_idle_pc", pc_output, 16'd0);
        pulse_step();
        repeat (12) @(posedge clk);
        #1;
        chk("step1_pc", pc_output, 16'd1);
        chk("step1_state", current_state_output, 3'd0);
        chk("step1_req", imem_req, 1'b0);
        pulse_step();
        repeat (12) @(posedge clk);
        #1;
        chk("step2_data", data_output, 16'h0007);
        chk("step2_pc", pc_output, 16'd2);
        step_mode = 1'b0;
        wait_halt(200, cyc);
        chk("step_halt_pc", pc_output, 16'd2);

        // Sticky illegal opcode, then an asynchronous reset in the middle of a fetch.
        assert_reset();
        mem[0] = 16'h1009; mem[1] = 16'h7000; mem[2] = 16'hA000;
        mem[3] = 16'hF000; mem[4] = 16'h0000; mem[5] = 16'hF000;
        release_reset(1, 1'b0);
        wait_halt(300, cyc);
        chk("ill_set", illegal_op, 1'b1);
        chk("ill_data", data_output, 16'h0009);
        chk("ill_pc", pc_output, 16'd3);
        pulse_resume();
        wait_halt(300, cyc);
        chk("ill_sticky", illegal_op, 1'b1);
        chk("ill_pc2", pc_output, 16'd5);
        pulse_resume();
        cyc = 0;
        while (current_state_output != 3'd1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("reach_wait", current_state_output, 3'd1);
        chk("wait_req", imem_req, 1'b1);
        #1 reset = 1'b0;
        #1;
        chk("arst_state", current_state_output, 3'd0);
        chk("arst_pc", pc_output, 16'd0);
        chk("arst_req", imem_req, 1'b0);
        chk("arst_data", data_output, 16'd0);
        chk("arst_illegal", illegal_op, 1'b0);

        // Randomized programs, ack delays, step-mode toggling, and resume/step noise.
        assert_reset();
        for (int i = 0; i < 256; i++) mem[i] = gen_instr();
        release_reset(2, 1'b0);
        for (int k = 0; k < 6000; k++) begin
            @(posedge clk); #1;
            resume = 1'b0;
            step   = 1'b0;
            if (halted && $urandom_range(0, 3) == 0) resume = 1'b1;
            if (!halted && $urandom_range(0, 19) == 0) resume = 1'b1;
            if ($urandom_range(0, 199) == 0) step_mode = ~step_mode;
            if ($urandom_range(0, 5) == 0) step = 1'b1;
        end
        @(posedge clk); #1;
        resume = 1'b0;
        step   = 1'b0;
        chk("random_progress", {31'd0, c_idx > 150}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Watchdog timer: ends the run if the bench itself stalls.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, got %0d passed of %0d", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
